// File: rtl/difftest_io_pkg.sv
// Shared constants for the difftest I/O bridge: parameter defaults, counter width
// and the console "no character" sentinel.
package difftest_io_pkg;

  localparam int DEFAULT_STEPWIDTH    = 8;
  localparam int DEFAULT_FIFO_DEPTH   = 8;
  localparam int DEFAULT_BATCH        = 32;
  localparam int DEFAULT_IDLE_TIMEOUT = 16;
  localparam int CYCLE_WIDTH          = 64;

  localparam logic [7:0] UART_NO_CHAR = 8'hff;

  // The testbench console reports "nothing typed" with the sentinel byte.
  function automatic logic is_real_char(input logic [7:0] ch);
    return ch != UART_NO_CHAR;
  endfunction

endpackage

// File: rtl/difftest_byte_fifo.sv
// Byte-wide synchronous FIFO used to buffer core UART output toward the console.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module difftest_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/difftest_io_bridge.sv
// Glue between the simulated core and the difftest harness: batches commit counts
// into step pulses, buffers UART TX, holds one RX byte and gates logging by cycle.
module difftest_io_bridge
  import difftest_io_pkg::*;
#(
  parameter int STEPWIDTH    = DEFAULT_STEPWIDTH,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int BATCH        = DEFAULT_BATCH,
  parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STEPWIDTH-1:0]   commit_cnt,
  output logic [STEPWIDTH-1:0]   step,
  input  logic                   tx_valid,
  input  logic [7:0]             tx_data,
  output logic                   tx_ready,
  output logic                   uart_out_valid,
  output logic [7:0]             uart_out_ch,
  input  logic                   uart_in_valid,
  input  logic [7:0]             uart_in_ch,
  output logic                   rx_valid,
  output logic [7:0]             rx_data,
  input  logic                   rx_ready,
  input  logic [CYCLE_WIDTH-1:0] log_begin,
  input  logic [CYCLE_WIDTH-1:0] log_end,
  output logic                   log_en
);

  localparam int AW = STEPWIDTH + 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW-1:0] BATCH_THRESHOLD = AW'(BATCH);
  localparam logic [IW-1:0] IDLE_LAST       = IW'(IDLE_TIMEOUT - 1);

  logic [AW-1:0]          acc;
  logic [AW-1:0]          sum;
  logic [IW-1:0]          idle_cnt;
  logic                   commit_zero;
  logic                   flush;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [7:0]             fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic                   rx_capture;
  logic [CYCLE_WIDTH-1:0] cycle_cnt;

  // acc stays below BATCH between flushes, so sum < 2*BATCH always fits in step.
  always_comb begin
    sum         = acc + {1'b0, commit_cnt};
    commit_zero = (commit_cnt == '0);
    flush       = (sum >= BATCH_THRESHOLD) ||
                  ((sum != '0) && commit_zero && (idle_cnt == IDLE_LAST));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc      <= '0;
      idle_cnt <= '0;
      step     <= '0;
    end else if (flush) begin
      step     <= sum[STEPWIDTH-1:0];
      acc      <= '0;
      idle_cnt <= '0;
    end else begin
      step <= '0;
      acc  <= sum;
      if (!commit_zero) begin
        idle_cnt <= '0;
      end else if (acc != '0) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  assign tx_ready  = reset && !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign fifo_pop  = !fifo_empty;

  difftest_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(tx_data),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      uart_out_valid <= 1'b0;
      uart_out_ch    <= '0;
    end else begin
      uart_out_valid <= !fifo_empty;
      if (!fifo_empty) uart_out_ch <= fifo_head;
    end
  end

  // A byte arriving while the held one is still unconsumed is dropped on purpose.
  assign rx_capture = uart_in_valid && is_real_char(uart_in_ch) && (!rx_valid || rx_ready);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (rx_capture) begin
      rx_valid <= 1'b1;
      rx_data  <= uart_in_ch;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_cnt <= '0;
      log_en    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + CYCLE_WIDTH'(1);
      log_en    <= (cycle_cnt >= log_begin) && (cycle_cnt < log_end);
    end
  end

endmodule

// File: doc/difftest_io_bridge.md
DIFFTEST_IO_BRIDGE -- requirements
Module: difftest_io_bridge

Interface
REQ-001 SHALL have parameter STEPWIDTH, default 8, width of commit_cnt and step.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, UART TX FIFO entries (power of 2, ≥2).
REQ-003 SHALL have parameter BATCH, default 32, step flush threshold; BATCH ≤ 2^(STEPWIDTH-1).
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 16, zero-commit cycles before partial flush; ≥1.
REQ-005 SHALL have port clock, input, 1, clock.
REQ-006 SHALL have port reset, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port commit_cnt, input, STEPWIDTH, instructions committed this cycle; source guarantees ≤ BATCH.
REQ-008 SHALL have port step, output, STEPWIDTH, batched commit count to difftest_step; 0 = no step.
REQ-009 SHALL have port tx_valid, input, 1, core UART byte valid.
REQ-010 SHALL have port tx_data, input, 8, core UART byte.
REQ-011 SHALL have port tx_ready, output, 1, FIFO accepts byte.
REQ-012 SHALL have port uart_out_valid, output, 1, byte to testbench console.
REQ-013 SHALL have port uart_out_ch, output, 8, console byte.
REQ-014 SHALL have port uart_in_valid, input, 1, testbench input strobe.
REQ-015 SHALL have port uart_in_ch, input, 8, testbench input byte; 8'hff = no character.
REQ-016 SHALL have port rx_valid, output, 1, received byte held for core.
REQ-017 SHALL have port rx_data, output, 8, received byte.
REQ-018 SHALL have port rx_ready, input, 1, core consumes rx_data.
REQ-019 SHALL have ports log_begin and log_end, input, 64 each, log window bounds in cycles.
REQ-020 SHALL have port log_en, output, 1, cycle inside log window.

Function
REQ-021 Step batcher: acc (STEPWIDTH+1 bits); sum = acc + commit_cnt each cycle.
REQ-022 Flush when sum ≥ BATCH, or sum ≠ 0 and commit_cnt = 0 on the IDLE_TIMEOUT-th consecutive zero-commit cycle; flush registers step ← sum next cycle, acc ← 0, idle count ← 0.
REQ-023 No flush: step ← 0, acc ← sum; idle count increments only when acc ≠ 0 and commit_cnt = 0, clears on any nonzero commit_cnt.
REQ-024 step SHALL be nonzero for exactly one cycle per flush; no commit ever lost or double-counted; max emitted 2·BATCH−1.
REQ-025 TX: tx_ready = !full; push on tx_valid && tx_ready; no push when full even if popping same cycle.
REQ-026 TX drain: each cycle FIFO non-empty, pop head, register uart_out_valid=1, uart_out_ch=head; otherwise uart_out_valid=0; one byte/cycle, FIFO order.
REQ-027 TX latency: byte pushed into empty FIFO in cycle t appears on uart_out in cycle t+2.
REQ-028 RX: capture when uart_in_valid && uart_in_ch ≠ 8'hff && (!rx_valid || rx_ready); rx_valid=1, rx_data set next cycle.
REQ-029 RX: rx_valid && rx_ready with no new capture clears rx_valid next cycle; byte arriving while rx_valid && !rx_ready SHALL be dropped, held byte unchanged.
REQ-030 Cycle counter: 64-bit, 0 in first cycle after reset release, +1 per cycle, wraps.
REQ-031 log_en registered: log_en ← (cnt ≥ log_begin) && (cnt < log_end); log_end ≤ log_begin yields log_en = 0 always.

Reset
REQ-032 While reset=0: step=0, tx_ready=0, uart_out_valid=0, uart_out_ch=0, rx_valid=0, rx_data=0, log_en=0; acc, idle, counter, FIFO pointers cleared.
REQ-033 Reset mid-operation SHALL discard pending commits, queued TX bytes and held RX byte; no output pulse on release.

Structure
REQ-034 Package difftest_io_pkg SHALL hold parameter defaults and constant UART_NO_CHAR = 8'hff.
REQ-035 TX FIFO SHALL be sub-module difftest_byte_fifo (push/pop, full/empty); remainder inline.

Verification
REQ-036 commit_cnt=4 cycles c0..c7 → step=32 in c8 only, 0 otherwise.
REQ-037 commit_cnt=5 in c0 then 0 → step=5 in c17 only (IDLE_TIMEOUT=16).
REQ-038 commit_cnt=20 c0, 20 c1 → step=40 in c2; acc 0 afterwards.
REQ-039 Push 10 bytes 0x41.. back-to-back, FIFO_DEPTH=8 → tx_ready drops when full, uart_out emits all 10 in order, none lost.
REQ-040 uart_in 0x61 with rx_ready=0, then 0x62, then 0xff → rx_data stays 0x61; after rx_ready=1 rx_valid clears; 0xff never captured.
REQ-041 log_begin=10, log_end=12 → log_en=1 exactly two cycles (cnt 10,11, visible one cycle later); reset asserted mid-window → log_en=0 next cycle.
